program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 15 +
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader_load_csum.sv | 39 +++
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared loader definitions: data word width and the loader FSM state encoding.
package proc_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Loader stream-input handshake and program-memory write port, with loader (slave) and host (master) views.
interface program_loader_if #(
  parameter int ROM_SIZE = 16
) ();
  import proc_pkg::*;

  logic                in_valid;
  logic [WORD_W-1:0]   in_data;
  logic                in_ready;
  logic                prog_we;
  logic [ROM_SIZE-1:0] prog_addr;
  logic [WORD_W-1:0]   prog_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, prog_we, prog_addr, prog_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, prog_we, prog_addr, prog_data
  );

endinterface

// File: rtl/program_loader_load_csum.sv
// 16-bit modular accumulator with synchronous clear and add-enable for the load checksum.
module load_csum
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [WORD_W-1:0] add_data,
  output logic [WORD_W-1:0] sum
);

  logic [WORD_W-1:0] sum_q;
  logic [WORD_W-1:0] sum_d;

  // Next sum: clear wins over add; carries out of bit 15 are discarded.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = {WORD_W{1'b0}};
    end else if (add_en) begin
      sum_d = sum_q + add_data;
    end else begin
      sum_d = sum_q;
    end
  end

  // Sum register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= {WORD_W{1'b0}};
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: streams a length-prefixed image into program memory, then releases the core.
// Optional LOADER_CHECKSUM_EN: a trailing 16-bit additive checksum is verified in a CHECK state.
module program_loader
  import proc_pkg::*;
#(
  parameter int ROM_SIZE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  program_loader_if.slave bus,
  output logic           cpu_rst,
  output logic           busy,
  output logic           done,
  output logic           err
);

  // Largest image that fits in memory; only meaningful when ROM_SIZE < WORD_W.
  localparam logic [WORD_W:0] MAX_WORDS = {{WORD_W{1'b0}}, 1'b1} << ROM_SIZE;

  loader_state_e       state_q, state_d;
  logic [WORD_W-1:0]   len_q, len_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [ROM_SIZE-1:0] prog_addr_q, prog_addr_d;
  logic [WORD_W-1:0]   prog_data_q, prog_data_d;
  logic                prog_we_q, prog_we_d;
  logic                xfer_s;
  logic                last_s;
  logic                hdr_too_big_s;

  assign xfer_s        = bus.in_valid & bus.in_ready;
  assign last_s        = (cnt_q == (len_q - 16'd1));
  assign hdr_too_big_s = (ROM_SIZE < WORD_W) && ({1'b0, bus.in_data} > MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  logic              csum_clr_s;
  logic              csum_add_s;
  logic [WORD_W-1:0] csum_s;

  assign csum_clr_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign csum_add_s = xfer_s && (state_q == ST_LOAD);

  load_csum u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (csum_clr_s),
    .add_en   (csum_add_s),
    .add_data (bus.in_data),
    .sum      (csum_s)
  );
`endif

  // Session FSM and write-register next state; a stalled cycle holds everything.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_we_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d     = ST_HEADER;
          cnt_d       = 16'd0;
          prog_addr_d = {ROM_SIZE{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_HEADER: begin
        if (xfer_s) begin
          len_d = bus.in_data;
          if (bus.in_data == 16'd0) begin
            state_d = ST_DONE;
          end else if (hdr_too_big_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          prog_we_d   = 1'b1;
          prog_addr_d = cnt_q[ROM_SIZE-1:0];
          prog_data_d = bus.in_data;
          cnt_d       = cnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          if (last_s) state_d = ST_CHECK;
          else        state_d = state_q;
`else
          if (last_s) state_d = ST_DONE;
          else        state_d = state_q;
`endif
        end else begin
          state_d = state_q;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer_s) begin
          state_d = (bus.in_data == csum_s) ? ST_DONE : ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and the one-cycle-latency write register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      prog_addr_q <= {ROM_SIZE{1'b0}};
      prog_data_q <= 16'd0;
      prog_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_we_q   <= prog_we_d;
    end
  end

  assign busy          = (state_q == ST_HEADER) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign bus.in_ready  = busy;
  assign done          = (state_q == ST_DONE);
  assign err           = (state_q == ST_ERR);
  assign cpu_rst       = done;
  assign bus.prog_we   = prog_we_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a 16-bit-address and a 2-bit-address instance, random sessions.
module tb_program_loader;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic cpu_rst0, busy0, done0, err0;
  logic cpu_rst1, busy1, done1, err1;
  logic [15:0] stim_q[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] got0, got1;
  int n_checks = 0;
  int n_fail = 0;

  program_loader_if #(.ROM_SIZE(16)) bus0 ();
  program_loader_if #(.ROM_SIZE(2))  bus1 ();

  program_loader #(.ROM_SIZE(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0.slave),
    .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .err(err0)
  );

  program_loader #(.ROM_SIZE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1.slave),
    .cpu_rst(cpu_rst1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitors: every prog_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus0.prog_we === 1'b1) begin
      got0 = {bus0.prog_addr, bus0.prog_data};
      if (exp_q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut0_extra_write: got addr/data 0x%0h, expected no write", got0);
      end else begin
        chk("dut0_write", got0, exp_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.prog_we === 1'b1) begin
      got1 = {14'd0, bus1.prog_addr, bus1.prog_data};
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_extra_write: got addr/data 0x%0h, expected no write", got1);
      end else begin
        chk("dut1_write", got1, exp_q1.pop_front());
      end
    end
  end

  task automatic drive(input int sel, input logic v, input logic [15:0] d);
    if (sel == 0) begin bus0.in_valid = v; bus0.in_data = d; end
    else          begin bus1.in_valid = v; bus1.in_data = d; end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  // Reference model: expected writes from the image rules, plus accepted word count and outcome.
  task automatic model(input int sel, output int n_acc, output bit ok);
    int rom;
    int n;
    logic [31:0] e;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;
    sum = 16'h0000;
`endif
    rom = (sel == 0) ? 16 : 2;
    n = int'(stim_q[0]);
    ok = 1'b1;
    n_acc = 1;
    if (n != 0 && rom < 16 && n > (1 << rom)) begin
      ok = 1'b0;
    end else if (n != 0) begin
      for (int k = 0; k < n; k++) begin
        e = {16'(k % (1 << rom)), stim_q[k + 1]};
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
`ifdef LOADER_CHECKSUM_EN
        sum = sum + stim_q[k + 1];
`endif
      end
      n_acc = n + 1;
`ifdef LOADER_CHECKSUM_EN
      ok = (sum == stim_q[n + 1]);
      n_acc = n + 2;
`endif
    end
  endtask

  task automatic build(input int n, input bit good);
    logic [15:0] w;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;
    sum = 16'h0000;
`endif
    stim_q.delete();
    stim_q.push_back(16'(n));
    for (int k = 0; k < n; k++) begin
      w = 16'($urandom);
      stim_q.push_back(w);
`ifdef LOADER_CHECKSUM_EN
      sum = sum + w;
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    if (n != 0) stim_q.push_back(good ? sum : (sum ^ 16'h0100));
`else
    if (good) stim_q.push_back(16'($urandom));
`endif
  endtask

  task automatic pulse_start(input int sel);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
  endtask

  task automatic send_word(input int sel, input logic [15:0] w);
    bit rdy;
    int budget;
    rdy = 1'b0;
    budget = 0;
    drive(sel, 1'b1, w);
    while (!rdy && budget < 40) begin
      rdy = get_ready(sel);
      @(posedge clk); #1;
      budget++;
    end
    if (!rdy) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: dut%0d in_ready stayed 0, expected 1", sel);
    end
  endtask

  task automatic check_outcome(input int sel, input bit ok);
    if (sel == 0) begin
      chk("dut0_done", done0, ok); chk("dut0_err", err0, !ok);
      chk("dut0_cpu_rst", cpu_rst0, ok); chk("dut0_busy", busy0, 1'b0);
    end else begin
      chk("dut1_done", done1, ok); chk("dut1_err", err1, !ok);
      chk("dut1_cpu_rst", cpu_rst1, ok); chk("dut1_busy", busy1, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input int sel);
    if (sel == 0) begin
      chk("rst0_in_ready", bus0.in_ready, 1'b0); chk("rst0_prog_we", bus0.prog_we, 1'b0);
      chk("rst0_prog_addr", bus0.prog_addr, 16'd0); chk("rst0_prog_data", bus0.prog_data, 16'd0);
      chk("rst0_cpu_rst", cpu_rst0, 1'b0); chk("rst0_busy", busy0, 1'b0);
      chk("rst0_done", done0, 1'b0); chk("rst0_err", err0, 1'b0);
    end else begin
      chk("rst1_in_ready", bus1.in_ready, 1'b0); chk("rst1_prog_we", bus1.prog_we, 1'b0);
      chk("rst1_prog_addr", bus1.prog_addr, 2'd0); chk("rst1_prog_data", bus1.prog_data, 16'd0);
      chk("rst1_cpu_rst", cpu_rst1, 1'b0); chk("rst1_busy", busy1, 1'b0);
      chk("rst1_done", done1, 1'b0); chk("rst1_err", err1, 1'b0);
    end
  endtask

  // One complete session on dut<sel>: stall < 0 picks random gaps of 0..2 cycles.
  task automatic session(input int sel, input int stall);
    int n_acc;
    bit ok;
    int st;
    model(sel, n_acc, ok);
    pulse_start(sel);
    for (int i = 0; i < n_acc; i++) begin
      send_word(sel, stim_q[i]);
      if (i < n_acc - 1) begin
        st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int s = 0; s < st; s++) begin
          drive(sel, 1'b0, 16'($urandom));
          set_start(sel, 1'($urandom_range(0, 1)));
          @(posedge clk); #1;
          set_start(sel, 1'b0);
        end
      end
    end
    drive(sel, 1'b0, 16'h0000);
    check_outcome(sel, ok);
    drive(sel, 1'b1, 16'($urandom));
    repeat (2) begin @(posedge clk); #1; end
    chk((sel == 0) ? "dut0_idle_ready" : "dut1_idle_ready", get_ready(sel), 1'b0);
    drive(sel, 1'b0, 16'h0000);
    chk((sel == 0) ? "dut0_pending_writes" : "dut1_pending_writes",
        (sel == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
  endtask

  initial begin
    int sel;
    int n;
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic three-word load, then the same load with two-cycle gaps.
    stim_q = '{16'd3, 16'hA001, 16'hA002, 16'hA003};
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(16'hE006);
`endif
    session(0, 0);
    session(0, 2);

    // Empty image.
    stim_q = '{16'd0};
    session(0, 0);

`ifdef LOADER_CHECKSUM_EN
    stim_q = '{16'd2, 16'h0001, 16'h0002, 16'h0004};
    session(0, 0);
    stim_q = '{16'd2, 16'h0001, 16'h0002, 16'h0003};
    session(0, 0);
`endif

    // Reset in the middle of a five-word load.
    stim_q = '{16'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    exp_q0.push_back({16'd0, 16'h1111});
    pulse_start(0);
    for (int i = 0; i < 3; i++) send_word(0, stim_q[i]);
    rst = 1'b0;
    #1;
    check_reset_outputs(0);
    drive(0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("midload_reset_pending", exp_q0.size(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    build(5, 1'b1);
    session(0, -1);

    // Small memory: oversize header, then an exactly-full image.
    build(5, 1'b1);
    session(1, 0);
    build(4, 1'b1);
    session(1, 0);

    for (int r = 0; r < 16; r++) begin
      sel = int'($urandom_range(0, 1));
      n = (sel == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 6));
      build(n, ($urandom_range(0, 3) != 0));
      session(sel, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
